// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 on key accept, then one PC-2 subkey per handshake.
// Optional macro DES_KEY_PARITY_EN adds an advisory odd-parity check on the key bytes.
module des_key_schedule #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [1:48] subkey,
  output logic [4:0]  key_num,
  output logic        sk_last,
  output logic        key_parity_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [6:0] PC1_T [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};

  localparam logic [5:0] PC2_T [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  function automatic logic [1:0] sh_of(input logic [4:0] r);
    case (r)
      5'd1, 5'd2, 5'd9, 5'd16: sh_of = 2'd1;
      default:                 sh_of = 2'd2;
    endcase
  endfunction

  // Total rotation after ROUNDS rounds; decrypt starts from the last round's C/D.
  function automatic int dec_shift(input int n);
    int s;
    s = 0;
    for (int r = 1; r <= n; r++) s += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
    return s % 28;
  endfunction

  localparam int DEC_S = dec_shift(ROUNDS);

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotl = {x[26:0], x[27]};
      2'd2:    rotl = {x[25:0], x[27:26]};
      default: rotl = x;
    endcase
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {x[0], x[27:1]};
      2'd2:    rotr = {x[1:0], x[27:2]};
      default: rotr = x;
    endcase
  endfunction

  function automatic logic [27:0] rotl_const(input logic [27:0] x, input int s);
    return (x << s) | (x >> (28 - s));
  endfunction

  function automatic logic [55:0] pc1(input logic [1:64] k);
    logic [55:0] o;
    o = 56'd0;
    for (int i = 0; i < 56; i++) o = {o[54:0], k[PC1_T[i]]};
    return o;
  endfunction

  // cd[55] holds DES position 1, so position p lives at bit 56-p.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = 48'd0;
    for (int i = 0; i < 48; i++) o = {o[46:0], cd[6'd56 - PC2_T[i]]};
    return o;
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [4:0]  key_num_q, key_num_d;
  logic        sk_last_q, sk_last_d;
  logic        dec_q, dec_d;
  logic [55:0] cd0_s;

  assign cd0_s     = pc1(key_in);
  assign key_ready = (state_q == IDLE);
  assign sk_valid  = (state_q == RUN);
  assign subkey    = pc2({c_q, d_q});
  assign key_num   = key_num_q;
  assign sk_last   = sk_last_q;

  // Next-state logic for load, advance and sequence completion.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    key_num_d = key_num_q;
    sk_last_d = sk_last_q;
    dec_d     = dec_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d   = RUN;
          dec_d     = decrypt;
          sk_last_d = (ROUNDS == 1);
          if (decrypt) begin
            c_d       = rotl_const(cd0_s[55:28], DEC_S);
            d_d       = rotl_const(cd0_s[27:0], DEC_S);
            key_num_d = 5'(ROUNDS);
          end else begin
            c_d       = rotl(cd0_s[55:28], 2'd1);
            d_d       = rotl(cd0_s[27:0], 2'd1);
            key_num_d = 5'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (sk_ready) begin
          if (sk_last_q) begin
            state_d   = IDLE;
            key_num_d = 5'd0;
            sk_last_d = 1'b0;
          end else if (dec_q) begin
            c_d       = rotr(c_q, sh_of(key_num_q));
            d_d       = rotr(d_q, sh_of(key_num_q));
            key_num_d = key_num_q - 5'd1;
            sk_last_d = (key_num_q == 5'd2);
          end else begin
            c_d       = rotl(c_q, sh_of(key_num_q + 5'd1));
            d_d       = rotl(d_q, sh_of(key_num_q + 5'd1));
            key_num_d = key_num_q + 5'd1;
            sk_last_d = (key_num_q + 5'd1 == 5'(ROUNDS));
          end
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and key-schedule registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      c_q       <= 28'd0;
      d_q       <= 28'd0;
      key_num_q <= 5'd0;
      sk_last_q <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      d_q       <= d_d;
      key_num_q <= key_num_d;
      sk_last_q <= sk_last_d;
      dec_q     <= dec_d;
    end
  end

`ifdef DES_KEY_PARITY_EN
  function automatic logic odd_parity_err(input logic [1:64] k);
    logic [63:0] t;
    logic        e;
    t = k;
    e = 1'b0;
    for (int b = 0; b < 8; b++) begin
      e = e | ~(^t[7:0]);
      t = t >> 8;
    end
    return e;
  endfunction

  logic perr_q;

  // Parity flag captured at key acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else if (state_q == IDLE && key_valid) begin
      perr_q <= odd_parity_err(key_in);
    end else begin
      perr_q <= perr_q;
    end
  end

  assign key_parity_err = perr_q;
`else
  logic unused_parity_bits_s;
  assign unused_parity_bits_s = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                                  key_in[40], key_in[48], key_in[56], key_in[64]};
  assign key_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised bench for des_key_schedule with a per-round reference model (ROUNDS=16 and ROUNDS=4 instances).
module tb_des_key_schedule;

  localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_VEC    = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_VEC   = 48'hCB3D8B0E17F5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid, key_ready, decrypt, sk_valid, sk_ready, sk_last, key_parity_err;
  logic [63:0] key_in;
  logic [47:0] subkey;
  logic [4:0]  key_num;

  logic        key_valid4, key_ready4, decrypt4, sk_valid4, sk_ready4, sk_last4, key_parity_err4;
  logic [63:0] key_in4;
  logic [47:0] subkey4;
  logic [4:0]  key_num4;

  int n_checks = 0;
  int n_errors = 0;

  int pc1_t [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35,
                     27, 19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38,
                     30, 22, 14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int pc2_t [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7,
                     27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56,
                     34, 53, 46, 42, 50, 36, 29, 32};

  des_key_schedule #(.ROUNDS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .decrypt(decrypt), .sk_valid(sk_valid), .sk_ready(sk_ready), .subkey(subkey),
    .key_num(key_num), .sk_last(sk_last), .key_parity_err(key_parity_err));

  des_key_schedule #(.ROUNDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid4), .key_ready(key_ready4), .key_in(key_in4),
    .decrypt(decrypt4), .sk_valid(sk_valid4), .sk_ready(sk_ready4), .subkey(subkey4),
    .key_num(key_num4), .sk_last(sk_last4), .key_parity_err(key_parity_err4));

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // K_i = PC2 of C0/D0 each rotated left by the cumulative shift through round i.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int i);
    int          s;
    logic        cd0 [56];
    logic        cdi [56];
    logic [47:0] r;
    s = 0;
    for (int k = 1; k <= i; k++) s += (k == 1 || k == 2 || k == 9 || k == 16) ? 1 : 2;
    for (int j = 0; j < 56; j++) cd0[j] = key[64 - pc1_t[j]];
    for (int j = 0; j < 28; j++) begin
      cdi[j]      = cd0[(j + s) % 28];
      cdi[28 + j] = cd0[28 + (j + s) % 28];
    end
    for (int k = 0; k < 48; k++) r[47 - k] = cdi[pc2_t[k] - 1];
    return r;
  endfunction

  function automatic logic ref_perr(input logic [63:0] key);
    logic e;
    e = 1'b0;
`ifdef DES_KEY_PARITY_EN
    for (int b = 0; b < 8; b++) if ($countones(key[b*8 +: 8]) % 2 == 0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_key_ready"}, key_ready, 64'd1);
    check_value({tag, "_sk_valid"}, sk_valid, 64'd0);
    check_value({tag, "_sk_last"}, sk_last, 64'd0);
    check_value({tag, "_key_num"}, key_num, 64'd0);
    check_value({tag, "_subkey"}, subkey, 64'd0);
    check_value({tag, "_perr"}, key_parity_err, 64'd0);
  endtask

  task automatic run_key(input logic [63:0] key, input logic dec, input int stall_pct, input int abort_after);
    int   n, idx, cycles;
    logic perr;
    perr = ref_perr(key);
    check_value("key_ready_idle", key_ready, 64'd1);
    key_in = key; decrypt = dec; key_valid = 1'b1; sk_ready = 1'b0;
    @(posedge clk); #1;
    key_valid = 1'b0; key_in = {$urandom, $urandom}; decrypt = ~dec;
    check_value("perr_accept", key_parity_err, perr);
    n = 0; cycles = 0;
    while (n < 16 && cycles < 400) begin
      idx = dec ? 16 - n : n + 1;
      check_value("sk_valid", sk_valid, 64'd1);
      check_value("key_ready_run", key_ready, 64'd0);
      check_value("key_num", key_num, idx);
      check_value("subkey", subkey, ref_subkey(key, idx));
      check_value("sk_last", sk_last, (n == 15));
      check_value("perr_run", key_parity_err, perr);
      if (key[63:1] == KNOWN_KEY[63:1] && idx == 1)  check_value("k1_vector", subkey, K1_VEC);
      if (key[63:1] == KNOWN_KEY[63:1] && idx == 16) check_value("k16_vector", subkey, K16_VEC);
      sk_ready  = ($urandom_range(99) >= stall_pct);
      key_valid = ($urandom_range(3) == 0);
      key_in    = {$urandom, $urandom};
      decrypt   = $urandom_range(1);
      @(posedge clk); #1;
      cycles++;
      if (sk_ready) begin
        n++;
        if (n == abort_after) begin
          key_valid = 1'b0;
          #2 rst_n = 1'b0;
          #1 check_reset_outputs("abort");
          #3 rst_n = 1'b1;
          @(posedge clk); #1;
          check_value("abort_idle", key_ready, 64'd1);
          return;
        end
      end
    end
    check_value("seq_timeout", cycles < 400, 64'd1);
    key_valid = 1'b0; sk_ready = 1'b0;
    check_value("done_sk_valid", sk_valid, 64'd0);
    check_value("done_key_ready", key_ready, 64'd1);
    check_value("done_key_num", key_num, 64'd0);
    check_value("done_sk_last", sk_last, 64'd0);
    check_value("done_perr", key_parity_err, perr);
  endtask

  task automatic run_key4(input logic [63:0] key, input logic dec);
    int idx;
    key_in4 = key; decrypt4 = dec; key_valid4 = 1'b1; sk_ready4 = 1'b1;
    @(posedge clk); #1;
    key_valid4 = 1'b0;
    check_value("r4_perr", key_parity_err4, ref_perr(key));
    for (int n = 0; n < 4; n++) begin
      idx = dec ? 4 - n : n + 1;
      check_value("r4_sk_valid", sk_valid4, 64'd1);
      check_value("r4_key_num", key_num4, idx);
      check_value("r4_subkey", subkey4, ref_subkey(key, idx));
      check_value("r4_sk_last", sk_last4, (n == 3));
      @(posedge clk); #1;
    end
    check_value("r4_done_sk_valid", sk_valid4, 64'd0);
    check_value("r4_done_key_ready", key_ready4, 64'd1);
    sk_ready4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_in = 64'd0; decrypt = 1'b0; sk_ready = 1'b0;
    key_valid4 = 1'b0; key_in4 = 64'd0; decrypt4 = 1'b0; sk_ready4 = 1'b0;
    #1 check_reset_outputs("reset");
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    run_key(KNOWN_KEY, 1'b0, 0, 0);
    run_key(KNOWN_KEY, 1'b1, 0, 0);
    for (int t = 0; t < 6; t++) run_key({$urandom, $urandom}, 1'($urandom_range(1)), 30, 0);
    run_key({$urandom, $urandom}, 1'b0, 30, 7);
    run_key(KNOWN_KEY, 1'b0, 30, 0);
    run_key(KNOWN_KEY ^ 64'd1, 1'b0, 0, 0);
    run_key(KNOWN_KEY ^ 64'd1, 1'b1, 30, 0);
    run_key4(KNOWN_KEY, 1'b1);
    run_key4(KNOWN_KEY, 1'b0);
    run_key4(KNOWN_KEY ^ 64'd1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
